// File: rtl/window_gen_5x5_if.sv
// Raster pixel stream into the 5x5 window generator: one pixel per valid beat,
// no backpressure.
interface window_gen_5x5_if #(
   parameter int WIDTH = 8
) ();
   logic             i_valid;
   logic [WIDTH-1:0] i_pixel;

   modport master (output i_valid, output i_pixel);
   modport slave  (input  i_valid, input  i_pixel);
endinterface

// File: rtl/window_gen_5x5.sv
// Streaming 5x5 sliding-window generator for the MRELBP radius-2 path.
// Exposes outer ring, centre and the four inner diagonals; borders are never flagged valid.
module window_gen_5x5 #(
   parameter int WIDTH = 8,
   parameter int IMG_W = 64,
   parameter int IMG_H = 64,
   parameter int XW    = $clog2(IMG_W),
   parameter int YW    = $clog2(IMG_H)
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   window_gen_5x5_if.slave      i_px,
   output logic                 o_valid,
   output logic [WIDTH-1:0]     o_pixel_00,
   output logic [WIDTH-1:0]     o_pixel_01,
   output logic [WIDTH-1:0]     o_pixel_02,
   output logic [WIDTH-1:0]     o_pixel_03,
   output logic [WIDTH-1:0]     o_pixel_04,
   output logic [WIDTH-1:0]     o_pixel_10,
   output logic [WIDTH-1:0]     o_pixel_11,
   output logic [WIDTH-1:0]     o_pixel_13,
   output logic [WIDTH-1:0]     o_pixel_14,
   output logic [WIDTH-1:0]     o_pixel_20,
   output logic [WIDTH-1:0]     o_pixel_22,
   output logic [WIDTH-1:0]     o_pixel_24,
   output logic [WIDTH-1:0]     o_pixel_30,
   output logic [WIDTH-1:0]     o_pixel_31,
   output logic [WIDTH-1:0]     o_pixel_33,
   output logic [WIDTH-1:0]     o_pixel_34,
   output logic [WIDTH-1:0]     o_pixel_40,
   output logic [WIDTH-1:0]     o_pixel_41,
   output logic [WIDTH-1:0]     o_pixel_42,
   output logic [WIDTH-1:0]     o_pixel_43,
   output logic [WIDTH-1:0]     o_pixel_44,
   output logic [XW-1:0]        o_center_x,
   output logic [YW-1:0]        o_center_y,
   output logic                 o_frame_done
);

   logic [WIDTH-1:0] r_lines [4][IMG_W];
   logic [WIDTH-1:0] w_lo    [4];
   logic [WIDTH-1:0] r_win   [5][5];
   logic [XW-1:0]    r_col;
   logic [YW-1:0]    r_row;
   logic             w_col_last;
   logic             w_row_last;
   logic             w_win_ok;

   always_comb begin
      for (int unsigned k = 0; k < 4; k++) begin
         w_lo[k] = r_lines[k][r_col];
      end
      w_col_last = (r_col == XW'(IMG_W - 1));
      w_row_last = (r_row == YW'(IMG_H - 1));
      w_win_ok   = (r_row >= YW'(4)) && (r_col >= XW'(4));
   end

   // Cascade: each line passes the pixel it read this cycle on to the next line.
   always_ff @(posedge i_clk) begin
      if (!i_rst && i_px.i_valid) begin
         r_lines[0][r_col] <= i_px.i_pixel;
         for (int unsigned k = 1; k < 4; k++) begin
            r_lines[k][r_col] <= w_lo[k-1];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_win        <= '{default: '0};
         r_col        <= '0;
         r_row        <= '0;
         o_valid      <= 1'b0;
         o_frame_done <= 1'b0;
         o_center_x   <= '0;
         o_center_y   <= '0;
      end else if (i_px.i_valid) begin
         for (int unsigned r = 0; r < 5; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
               r_win[r][c] <= r_win[r][c+1];
            end
         end
         r_win[0][4] <= w_lo[3];
         r_win[1][4] <= w_lo[2];
         r_win[2][4] <= w_lo[1];
         r_win[3][4] <= w_lo[0];
         r_win[4][4] <= i_px.i_pixel;

         r_col <= w_col_last ? '0 : r_col + XW'(1);
         if (w_col_last) begin
            r_row <= w_row_last ? '0 : r_row + YW'(1);
         end

         o_valid      <= w_win_ok;
         o_frame_done <= w_col_last && w_row_last;
         if (w_win_ok) begin
            o_center_x <= r_col - XW'(2);
            o_center_y <= r_row - YW'(2);
         end
      end else begin
         o_valid      <= 1'b0;
         o_frame_done <= 1'b0;
      end
   end

   assign o_pixel_00 = r_win[0][0];
   assign o_pixel_01 = r_win[0][1];
   assign o_pixel_02 = r_win[0][2];
   assign o_pixel_03 = r_win[0][3];
   assign o_pixel_04 = r_win[0][4];
   assign o_pixel_10 = r_win[1][0];
   assign o_pixel_11 = r_win[1][1];
   assign o_pixel_13 = r_win[1][3];
   assign o_pixel_14 = r_win[1][4];
   assign o_pixel_20 = r_win[2][0];
   assign o_pixel_22 = r_win[2][2];
   assign o_pixel_24 = r_win[2][4];
   assign o_pixel_30 = r_win[3][0];
   assign o_pixel_31 = r_win[3][1];
   assign o_pixel_33 = r_win[3][3];
   assign o_pixel_34 = r_win[3][4];
   assign o_pixel_40 = r_win[4][0];
   assign o_pixel_41 = r_win[4][1];
   assign o_pixel_42 = r_win[4][2];
   assign o_pixel_43 = r_win[4][3];
   assign o_pixel_44 = r_win[4][4];

endmodule

// File: tb/tb_window_gen_5x5.sv
// Directed bench for window_gen_5x5 on an 8x6 image with pixel = row*16+col
// (or its 0xFF complement for the second back-to-back frame).
module tb_window_gen_5x5;
   localparam int W  = 8;
   localparam int IW = 8;
   localparam int IH = 6;
   localparam int XW = 3;
   localparam int YW = 3;
   localparam int TAPS [21] = '{0, 1, 2, 3, 4, 10, 11, 13, 14, 20, 22, 24,
                                30, 31, 33, 34, 40, 41, 42, 43, 44};

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   window_gen_5x5_if #(.WIDTH(W)) bus ();

   logic          ov, fd;
   logic [XW-1:0] cx;
   logic [YW-1:0] cy;
   logic [W-1:0]  p00, p01, p02, p03, p04, p10, p11, p13, p14, p20, p22,
                  p24, p30, p31, p33, p34, p40, p41, p42, p43, p44;

   window_gen_5x5 #(.WIDTH(W), .IMG_W(IW), .IMG_H(IH), .XW(XW), .YW(YW)) dut (
      .i_clk(clk), .i_rst(rst), .i_px(bus),
      .o_valid(ov),
      .o_pixel_00(p00), .o_pixel_01(p01), .o_pixel_02(p02), .o_pixel_03(p03),
      .o_pixel_04(p04), .o_pixel_10(p10), .o_pixel_11(p11), .o_pixel_13(p13),
      .o_pixel_14(p14), .o_pixel_20(p20), .o_pixel_22(p22), .o_pixel_24(p24),
      .o_pixel_30(p30), .o_pixel_31(p31), .o_pixel_33(p33), .o_pixel_34(p34),
      .o_pixel_40(p40), .o_pixel_41(p41), .o_pixel_42(p42), .o_pixel_43(p43),
      .o_pixel_44(p44),
      .o_center_x(cx), .o_center_y(cy), .o_frame_done(fd)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] tap(input int code);
      case (code)
         0:  return p00;  1:  return p01;  2:  return p02;  3:  return p03;
         4:  return p04;  10: return p10;  11: return p11;  13: return p13;
         14: return p14;  20: return p20;  22: return p22;  24: return p24;
         30: return p30;  31: return p31;  33: return p33;  34: return p34;
         40: return p40;  41: return p41;  42: return p42;  43: return p43;
         44: return p44;
         default: return '0;
      endcase
   endfunction

   function automatic logic [W-1:0] img(input int inv, input int row, input int col);
      logic [W-1:0] v;
      v = W'(row * 16 + col);
      return (inv != 0) ? (8'hFF - v) : v;
   endfunction

   task automatic step(input logic v, input logic [W-1:0] p);
      @(negedge clk);
      bus.i_valid = v;
      bus.i_pixel = p;
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input int inv, input bit gaps, input int stop_at, output int nv);
      int            row, col, ecx, ecy, r, c;
      logic          exp_v;
      logic [W-1:0]  h22, h44;
      logic [XW-1:0] hx;
      logic [YW-1:0] hy;
      nv = 0;
      for (int idx = 0; idx < stop_at; idx++) begin
         row = idx / IW;
         col = idx % IW;
         if (gaps) begin
            while ($urandom_range(0, 1) == 1) begin
               h22 = p22; h44 = p44; hx = cx; hy = cy;
               step(1'b0, 8'hA5);
               check("gap_valid", ov, 0);
               check("gap_fdone", fd, 0);
               check("gap_hold22", p22, h22);
               check("gap_hold44", p44, h44);
               check("gap_holdx", cx, hx);
               check("gap_holdy", cy, hy);
            end
         end
         step(1'b1, img(inv, row, col));
         exp_v = (row >= 4) && (col >= 4);
         check("valid", ov, exp_v);
         check("fdone", fd, idx == IW * IH - 1);
         if (exp_v) begin
            ecx = 2 + nv % (IW - 4);
            ecy = 2 + nv / (IW - 4);
            check("cx", cx, ecx);
            check("cy", cy, ecy);
            for (int t = 0; t < 21; t++) begin
               r = TAPS[t] / 10;
               c = TAPS[t] % 10;
               check($sformatf("tap%0d", TAPS[t]), tap(TAPS[t]), img(inv, ecy - 2 + r, ecx - 2 + c));
            end
            if (nv == 0 && inv == 0) begin
               check("first_00", p00, 8'h00);
               check("first_04", p04, 8'h04);
               check("first_22", p22, 8'h22);
               check("first_44", p44, 8'h44);
               check("first_31", p31, 8'h31);
               check("first_x", cx, 2);
               check("first_y", cy, 2);
            end
            if (nv == 0 && inv != 0) begin
               check("inv_first_22", p22, 8'hDD);
               check("inv_first_00", p00, 8'hFF);
            end
            if (nv == 7 && inv == 0) check("last_44", p44, 8'h57);
            nv++;
         end
      end
   endtask

   initial begin
      int nv;
      bus.i_valid = 1'b0;
      bus.i_pixel = '0;
      rst = 1'b1;
      repeat (3) step(1'b0, '0);
      check("rst_valid", ov, 0);
      check("rst_fdone", fd, 0);
      check("rst_x", cx, 0);
      check("rst_y", cy, 0);
      check("rst_22", p22, 0);
      check("rst_44", p44, 0);
      @(negedge clk);
      rst = 1'b0;

      run_frame(0, 1'b0, IW * IH, nv);
      check("count_cont", nv, 8);

      run_frame(0, 1'b1, IW * IH, nv);
      check("count_gaps", nv, 8);
      step(1'b0, '0);
      check("post_gap_valid", ov, 0);

      run_frame(0, 1'b0, 40, nv);
      check("count_partial", nv, 4);
      @(negedge clk);
      rst = 1'b1;
      bus.i_valid = 1'b1;
      bus.i_pixel = img(0, 5, 0);
      @(posedge clk);
      #1;
      check("midrst_valid", ov, 0);
      check("midrst_fdone", fd, 0);
      check("midrst_x", cx, 0);
      check("midrst_y", cy, 0);
      check("midrst_00", p00, 0);
      check("midrst_22", p22, 0);
      step(1'b1, img(0, 5, 1));
      check("midrst2_valid", ov, 0);
      @(negedge clk);
      rst = 1'b0;
      bus.i_valid = 1'b0;

      run_frame(0, 1'b0, IW * IH, nv);
      check("count_after_rst", nv, 8);
      run_frame(1, 1'b0, IW * IH, nv);
      check("count_b2b", nv, 8);

      step(1'b0, '0);
      check("idle_valid", ov, 0);
      check("idle_fdone", fd, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/window_gen_5x5.md
Name: window_gen_5x5

Overview:
- Streaming 5x5 sliding-window generator for the MRELBP radius-2 path.
- Accepts one raster-order pixel per valid cycle and buffers four image lines.
- Presents the 21 window taps consumed by the radius-2 interpolation stage: full outer ring plus centre, no inner-ring taps except (1,1),(1,3),(3,1),(3,3).
- Pulses a valid flag only for windows lying entirely inside the image; borders are not padded.

Parameters:
- WIDTH, 8, pixel width in bits.
- IMG_W, 64, image width in pixels (>=5).
- IMG_H, 64, image height in pixels (>=5).
- XW, $clog2(IMG_W), column counter / coordinate width.
- YW, $clog2(IMG_H), row counter / coordinate width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_valid  in  1  i_pixel is valid this cycle; pixel is consumed unconditionally (no backpressure).
- i_pixel  in  WIDTH  raster-order input pixel.
- o_valid  out  1  window outputs valid; one-cycle pulse per window.
- o_pixel_rc  out  WIDTH each  window taps, r = row 0..4 (0 = top/oldest), c = col 0..4 (0 = left/oldest). Exactly these 21: 00,01,02,03,04,10,11,13,14,20,22,24,30,31,33,34,40,41,42,43,44.
- o_center_x  out  XW  image column of tap 22.
- o_center_y  out  YW  image row of tap 22.
- o_frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Storage:
  - Four line buffers, depth IMG_W, each WIDTH bits, cascaded. Line k holds the row k+1 rows above the incoming row.
  - 5x5 register array.
  - On each accepted pixel, array rows shift left by one column. Column 4 loads {line3_out, line2_out, line1_out, line0_out, i_pixel} into rows 0..4.
  - Line buffers write at the current column address.
- Counters:
  - col_cnt 0..IMG_W-1 increments per accepted pixel and wraps to 0.
  - row_cnt increments on col wrap and wraps to 0 after IMG_H-1.
  - On the last pixel (col IMG_W-1, row IMG_H-1), both counters return to 0 and o_frame_done pulses on the next cycle.
- Validity:
  - The pixel accepted at (row_cnt, col_cnt) with row_cnt>=4 and col_cnt>=4 completes the window centred at (row_cnt-2, col_cnt-2).
  - On the next cycle: o_valid=1, o_center_y=row_cnt-2, o_center_x=col_cnt-2.
  - Windows straddling a line wrap (col_cnt<4) or the top rows (row_cnt<4) never assert o_valid.
  - Stale line-buffer data is permitted in masked windows.
- Tap mapping: o_pixel_rc = image(o_center_y-2+r, o_center_x-2+c).
- Latency: 1 clock from acceptance of the completing pixel to o_valid. Taps are registered outputs and are stable while o_valid=1.
- Idle (i_valid=0):
  - No shift, no counter change.
  - o_valid=0 and o_frame_done=0.
  - Tap and coordinate outputs hold their last values.
- Reset:
  - All outputs 0; col_cnt=row_cnt=0.
  - Window registers are cleared to 0. Line-buffer RAM is not cleared, since masking covers it.
  - Reset mid-frame aborts the frame. The next accepted pixel is treated as (0,0). No o_valid or o_frame_done is issued for the aborted frame after reset.
- i_rst has priority over i_valid in the same cycle.
- Count: exactly (IMG_W-4)*(IMG_H-4) o_valid pulses per frame, in raster order of centre.
- Back-to-back frames with continuous i_valid need no bubble. The first valid window of frame N+1 follows after 4*IMG_W+5 accepted pixels.

Test Plan:
- IMG_W=8, IMG_H=6, pixel = row*16+col, continuous i_valid:
  - First o_valid occurs exactly 1 cycle after pixel index 36 (row 4, col 4).
  - Expected taps: o_pixel_00=0x00, o_pixel_04=0x04, o_pixel_22=0x22, o_pixel_44=0x44, o_pixel_31=0x31.
  - Expected centre: (x=2, y=2).
- Same stimulus, full frame:
  - Exactly 8 o_valid pulses with centres (2..5, 2..3) in raster order.
  - Last window has o_pixel_44=0x57.
  - o_frame_done pulses once, 1 cycle after pixel 47.
- Same stimulus with random i_valid gaps (~50% duty):
  - Tap values and centre sequence are identical to the continuous case.
  - o_valid is never asserted in a cycle following i_valid=0.
  - Outputs hold across gaps.
- Line-wrap masking: no o_valid after pixels at col 0..3 of rows 4 and 5, even though the window registers contain mixed-row data.
- Assert i_rst at pixel index 40, then restart a fresh frame:
  - No o_valid for the aborted frame.
  - Outputs read 0 during reset.
  - The new frame's first o_valid follows its pixel 36, with o_pixel_22=0x22.
- Two back-to-back frames, second frame pixel = 0xFF - (row*16+col):
  - Second frame's first window gives o_pixel_22=0xDD and o_pixel_00=0xFF.
  - No valid pulse carries first-frame data.
